// File: rtl/neuron_target_gen39_if.sv
// neuron_target_gen39_if: bundles the request (start/layer_out/label) and the
// result/status signals of the 39-neuron training-target generator.
// master = the side that issues samples, slave = the generator itself.
`timescale 1ns/1ps
interface neuron_target_gen39_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic                   start;
  logic [38:0][DATA_W-1:0] layer_out;
  logic [5:0]             label;
  logic                   busy;
  logic [38:0][DATA_W-1:0] expected_out;
  logic [5:0]             pred_class;
  logic                   pred_correct;
  logic                   done;
  logic                   learn;
  logic [CNT_W-1:0]       hits;
  logic [CNT_W-1:0]       total;

  modport master (
    output start, layer_out, label,
    input  busy, expected_out, pred_class, pred_correct, done, learn, hits, total
  );

  modport slave (
    input  start, layer_out, label,
    output busy, expected_out, pred_class, pred_correct, done, learn, hits, total
  );
endinterface

// File: rtl/neuron_target_gen39.sv
// neuron_target_gen39: captures 39 layer outputs plus a label, scans them one
// per cycle for the argmax, then writes a training target vector that moves
// each output 2^-SHIFT of the way toward its ideal (1.0 for the labelled class,
// 0 elsewhere). Unlabelled samples (label >= 39) get the outputs echoed back.
// Optional hit/total statistics counters: define NEURON_TARGET_STATS_EN.
`timescale 1ns/1ps
module neuron_target_gen39 #(
  parameter int DATA_W = 8,
  parameter int SHIFT  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  neuron_target_gen39_if.slave   bus
);

  localparam int N = 39;
  localparam logic [DATA_W-1:0] MAX = {DATA_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SCAN, TARGET, EMIT} state_t;

  state_t                  state_q, state_d;
  logic [N-1:0][DATA_W-1:0] cap_q, cap_d;
  logic [5:0]              lab_q, lab_d;
  logic [5:0]              idx_q, idx_d;
  logic [5:0]              best_idx_q, best_idx_d;
  logic [DATA_W-1:0]       best_val_q, best_val_d;
  logic [N-1:0][DATA_W-1:0] exp_q, exp_d;
  logic [5:0]              pred_q, pred_d;
  logic                    corr_q, corr_d;

  logic                    labelled;
  logic                    correct_c;
  logic [DATA_W-1:0]       cur_val;

  // One learning step: cur + ((tgt - cur) >>> SHIFT) in signed W+1 bits.
  // The floor shift never overshoots the target, so the result stays in range.
  function automatic logic [DATA_W-1:0] step_toward(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] tgt);
    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] res;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    res  = $signed({1'b0, cur}) + (diff >>> SHIFT);
    return res[DATA_W-1:0];
  endfunction

  assign labelled  = (lab_q < 6'(N));
  assign correct_c = labelled && (best_idx_q == lab_q);
  assign cur_val   = cap_q[idx_q];

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SCAN;
      SCAN:    if (idx_q == 6'(N-1)) state_d = TARGET;
      TARGET:  state_d = EMIT;
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: status flags decoded from the current state
  always_comb begin
    bus.busy  = (state_q != IDLE);
    bus.done  = (state_q == EMIT);
    bus.learn = (state_q == EMIT) && labelled;
  end

  // Datapath next-state: capture, sequential argmax scan, parallel target write
  always_comb begin
    cap_d      = cap_q;
    lab_d      = lab_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    exp_d      = exp_q;
    pred_d     = pred_q;
    corr_d     = corr_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cap_d      = bus.layer_out;
          lab_d      = bus.label;
          idx_d      = '0;
          best_idx_d = '0;
          best_val_d = '0;
        end
      end
      SCAN: begin
        // strict compare: ties keep the earlier (lower) index
        if (cur_val > best_val_q) begin
          best_val_d = cur_val;
          best_idx_d = idx_q;
        end
        idx_d = idx_q + 6'd1;
      end
      TARGET: begin
        for (int i = 0; i < N; i++) begin
          if (labelled)
            exp_d[i] = step_toward(cap_q[i], (lab_q == 6'(i)) ? MAX : '0);
          else
            exp_d[i] = cap_q[i];
        end
        pred_d = best_idx_q;
        corr_d = correct_c;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any sample and clears visible results
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_q      <= '0;
      lab_q      <= '0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      exp_q      <= '0;
      pred_q     <= '0;
      corr_q     <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      lab_q      <= lab_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      exp_q      <= exp_d;
      pred_q     <= pred_d;
      corr_q     <= corr_d;
    end
  end

  assign bus.expected_out = exp_q;
  assign bus.pred_class   = pred_q;
  assign bus.pred_correct = corr_q;

`ifdef NEURON_TARGET_STATS_EN
  logic [CNT_W-1:0] hits_q, hits_d;
  logic [CNT_W-1:0] total_q, total_d;

  // Increment that sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Statistics update at the TARGET edge of labelled samples only
  always_comb begin
    hits_d  = hits_q;
    total_d = total_q;
    if (state_q == TARGET && labelled) begin
      total_d = sat_inc(total_q);
      if (correct_c) hits_d = sat_inc(hits_q);
    end
  end

  // Statistics registers, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hits_q  <= '0;
      total_q <= '0;
    end else begin
      hits_q  <= hits_d;
      total_q <= total_d;
    end
  end

  assign bus.hits  = hits_q;
  assign bus.total = total_q;
`else
  assign bus.hits  = '0;
  assign bus.total = '0;
`endif

endmodule

// File: tb/tb_neuron_target_gen39.sv
`timescale 1ns/1ps
module tb_neuron_target_gen39;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  neuron_target_gen39_if #(.DATA_W(8), .CNT_W(16)) bus ();
  neuron_target_gen39_if #(.DATA_W(8), .CNT_W(2))  bus2 ();

  assign bus2.start     = bus.start;
  assign bus2.layer_out = bus.layer_out;
  assign bus2.label     = bus.label;

  neuron_target_gen39 #(.DATA_W(8), .SHIFT(2), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );

  neuron_target_gen39 #(.DATA_W(8), .SHIFT(2), .CNT_W(2)) u_dut_sat (
    .clock(clock), .reset(reset), .bus(bus2.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [38:0][7:0] v;
  logic [38:0][7:0] v2;
  int lat;
  int seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] b);
    for (int i = 0; i < 39; i++) v[i] = b;
  endtask

  // Issue one sample from v, return cycles from the accepting edge to done.
  task automatic run_sample(input logic [5:0] lab, output int l);
    @(negedge clock);
    bus.layer_out = v;
    bus.label     = lab;
    bus.start     = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    l = 0;
    while (bus.done !== 1'b1 && l < 60) begin
      @(posedge clock); #1;
      l++;
    end
  endtask

  task automatic to_idle(input string tag);
    @(posedge clock); #1;
    chk({tag, "_done_clr"}, bus.done, 1'b0);
    chk({tag, "_busy_clr"}, bus.busy, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.label = '0;
    bus.layer_out = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_learn", bus.learn, 1'b0);
    chk("rst_corr", bus.pred_correct, 1'b0);
    chk("rst_pred", bus.pred_class, 6'd0);
    chk("rst_exp", bus.expected_out, '0);
    chk("rst_hits", bus.hits, 16'd0);
    chk("rst_total", bus.total, 16'd0);
    @(negedge clock);
    reset = 1'b0;

    // Argmax and targets
    fill(8'h03); v[5] = 8'h40; v[12] = 8'h80;
    run_sample(6'd5, lat);
    chk("A_latency", lat, 40);
    chk("A_done", bus.done, 1'b1);
    chk("A_learn", bus.learn, 1'b1);
    chk("A_busy", bus.busy, 1'b1);
    chk("A_pred", bus.pred_class, 6'd12);
    chk("A_corr", bus.pred_correct, 1'b0);
    for (int i = 0; i < 39; i++)
      chk($sformatf("A_exp%0d", i), bus.expected_out[i],
          (i == 5) ? 8'h6F : (i == 12) ? 8'h60 : 8'h02);
    to_idle("A");

    // Tie keeps lower index
    fill(8'h00); v[7] = 8'hFF; v[20] = 8'hFF;
    run_sample(6'd20, lat);
    chk("tie_pred", bus.pred_class, 6'd7);
    chk("tie_corr", bus.pred_correct, 1'b0);
    to_idle("tie");

    // All zero, label 0
    fill(8'h00);
    run_sample(6'd0, lat);
    chk("zero_pred", bus.pred_class, 6'd0);
    chk("zero_corr", bus.pred_correct, 1'b1);
    chk("zero_learn", bus.learn, 1'b1);
    chk("zero_exp0", bus.expected_out[0], 8'h3F);
    chk("zero_exp1", bus.expected_out[1], 8'h00);
    chk("zero_exp38", bus.expected_out[38], 8'h00);
    to_idle("zero");

    // Unlabelled: targets echo the capture
    for (int i = 0; i < 39; i++) v[i] = 8'(i * 3);
    run_sample(6'd45, lat);
    chk("unl_latency", lat, 40);
    chk("unl_done", bus.done, 1'b1);
    chk("unl_learn", bus.learn, 1'b0);
    chk("unl_corr", bus.pred_correct, 1'b0);
    chk("unl_pred", bus.pred_class, 6'd38);
    for (int i = 0; i < 39; i++)
      chk($sformatf("unl_exp%0d", i), bus.expected_out[i], 8'(i * 3));
    to_idle("unl");

    // Start held high: accepts at E0, E42, E84; layer_out change at E5 ignored
    fill(8'h10); v[3] = 8'h90;
    for (int i = 0; i < 39; i++) v2[i] = 8'h10;
    v2[9] = 8'hF0;
    @(negedge clock);
    bus.layer_out = v;
    bus.label     = 6'd3;
    bus.start     = 1'b1;
    for (int k = 0; k <= 84; k++) begin
      @(posedge clock); #1;
      if (k == 5) bus.layer_out = v2;
      if (k == 39) chk("hold_done_early", bus.done, 1'b0);
      if (k == 40) begin
        chk("hold_done1", bus.done, 1'b1);
        chk("hold_pred1", bus.pred_class, 6'd3);
        chk("hold_corr1", bus.pred_correct, 1'b1);
        chk("hold_exp3", bus.expected_out[3], 8'hAB);
        chk("hold_exp0", bus.expected_out[0], 8'h0C);
      end
      if (k == 41) chk("hold_busy41", bus.busy, 1'b0);
      if (k == 42) chk("hold_busy42", bus.busy, 1'b1);
      if (k == 82) begin
        chk("hold_done2", bus.done, 1'b1);
        chk("hold_pred2", bus.pred_class, 6'd9);
      end
      if (k == 83) chk("hold_busy83", bus.busy, 1'b0);
      if (k == 84) chk("hold_busy84", bus.busy, 1'b1);
    end
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 60) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("hold_latency3", lat, 40);
    to_idle("hold");

    // Reset mid-scan
    fill(8'h03); v[5] = 8'h40; v[12] = 8'h80;
    @(negedge clock);
    bus.layer_out = v;
    bus.label     = 6'd5;
    bus.start     = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_exp", bus.expected_out, '0);
    chk("abort_pred", bus.pred_class, 6'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (45) begin
      @(posedge clock); #1;
      if (bus.done === 1'b1) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_sample(6'd5, lat);
    chk("post_latency", lat, 40);
    chk("post_pred", bus.pred_class, 6'd12);
    chk("post_exp5", bus.expected_out[5], 8'h6F);
    to_idle("post");

    // Statistics: A above (wrong), then zero/label0 and tie/label7 (correct)
    fill(8'h00);
    run_sample(6'd0, lat);
    to_idle("st1");
    fill(8'h00); v[7] = 8'hFF; v[20] = 8'hFF;
    run_sample(6'd7, lat);
    chk("st2_corr", bus.pred_correct, 1'b1);
    to_idle("st2");
    fill(8'h22);
    run_sample(6'd50, lat);
    to_idle("st3");
`ifdef NEURON_TARGET_STATS_EN
    chk("stat_hits", bus.hits, 16'd2);
    chk("stat_total", bus.total, 16'd3);
`else
    chk("stat_hits", bus.hits, 16'd0);
    chk("stat_total", bus.total, 16'd0);
`endif
    fill(8'h00);
    repeat (3) begin
      run_sample(6'd0, lat);
      to_idle("st4");
    end
`ifdef NEURON_TARGET_STATS_EN
    chk("stat_hits5", bus.hits, 16'd5);
    chk("stat_total6", bus.total, 16'd6);
    chk("sat_hits", bus2.hits, 2'd3);
    chk("sat_total", bus2.total, 2'd3);
`else
    chk("stat_hits5", bus.hits, 16'd0);
    chk("stat_total6", bus.total, 16'd0);
    chk("sat_hits", bus2.hits, 2'd0);
    chk("sat_total", bus2.total, 2'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
